booth_mult_seq: RTL

Parametrised sequential radix-2 Booth multiplier producing a 2×WIDTH product split into `hi`/`lo`. It is the multi-cycle multiply unit for the datapath and is driven by the control FSM through a start/busy/done handshake. It generalises the fixed 32-bit signed multiplier with configurable width, correct handling of the most-negative operand, and an optional unsigned mode.

---
 rtl/mult_pkg.sv | 12 +
 rtl/booth_step.sv | 31 +++
 rtl/booth_mult_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// Shared constants for the sequential Booth multiplier: FSM state codes and
// the {Q[0], Q-1} pair encodings that select add/subtract.
package mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] BP_ADD  = 2'b01;
  localparam logic [1:0] BP_SUB  = 2'b10;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M into A, then an
// arithmetic right shift of {A, Q, Q-1}. Purely combinational.
module booth_step #(
  parameter int IW = 33
) (
  input  logic [IW-1:0] i_a,
  input  logic [IW-1:0] i_q,
  input  logic          i_q_m1,
  input  logic [IW-1:0] i_m,
  output logic [IW-1:0] o_a,
  output logic [IW-1:0] o_q,
  output logic          o_q_m1
);
  import mult_pkg::*;

  logic [IW-1:0] w_sum;

  always_comb begin
    w_sum = i_a;
    case ({i_q[0], i_q_m1})
      BP_ADD:  w_sum = i_a + i_m;
      BP_SUB:  w_sum = i_a + ~i_m + IW'(1);
      default: w_sum = i_a;
    endcase
  end

  assign o_a    = {w_sum[IW-1], w_sum[IW-1:1]};
  assign o_q    = {w_sum[0], i_q[IW-1:1]};
  assign o_q_m1 = i_q[0];

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier with start/busy/done handshake.
// Define BOOTH_UNSIGNED_EN to honour i_op_signed (unsigned mode, WIDTH+1 iterations).
//
//   state   | meaning
//   IDLE    | waiting for start
//   RUN     | one Booth iteration per cycle until the counter expires
//   DONE    | result valid, done pulse; start here is accepted back-to-back
module booth_mult_seq #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  input  logic             i_op_signed,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  import mult_pkg::*;

  localparam int IW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
`ifdef BOOTH_UNSIGNED_EN
  localparam int NITER = WIDTH + 1;
`else
  localparam int NITER = WIDTH;
`endif

  logic [1:0]         r_state;
  logic [IW-1:0]      r_m;
  logic [IW-1:0]      r_acc;
  logic [IW-1:0]      r_q;
  logic               r_q_m1;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_ext;
  logic [IW-1:0]      w_acc_nxt;
  logic [IW-1:0]      w_q_nxt;
  logic               w_q_m1_nxt;
  logic [2*WIDTH-1:0] w_prod;

`ifdef BOOTH_UNSIGNED_EN
  assign w_ext = i_op_signed;
`else
  logic w_unused_op_signed;
  assign w_unused_op_signed = i_op_signed;
  assign w_ext = 1'b1;
`endif

  booth_step #(.IW(IW)) u_step (
    .i_a    (r_acc),
    .i_q    (r_q),
    .i_q_m1 (r_q_m1),
    .i_m    (r_m),
    .o_a    (w_acc_nxt),
    .o_q    (w_q_nxt),
    .o_q_m1 (w_q_m1_nxt)
  );

  // With WIDTH iterations the skipped last step would be a pure shift (its
  // Booth pair is two copies of the sign bit), so take the product one bit up.
`ifdef BOOTH_UNSIGNED_EN
  assign w_prod = {w_acc_nxt[WIDTH-2:0], w_q_nxt};
`else
  assign w_prod = {w_acc_nxt[WIDTH-1:0], w_q_nxt[WIDTH:1]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_m     <= '0;
      r_acc   <= '0;
      r_q     <= '0;
      r_q_m1  <= 1'b0;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_acc  <= w_acc_nxt;
          r_q    <= w_q_nxt;
          r_q_m1 <= w_q_m1_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= ST_DONE;
            r_hi    <= w_prod[2*WIDTH-1:WIDTH];
            r_lo    <= w_prod[WIDTH-1:0];
          end
        end
        default: begin
          if (i_start) begin
            r_state <= ST_RUN;
            r_m     <= {w_ext & i_a[WIDTH-1], i_a};
            r_q     <= {w_ext & i_b[WIDTH-1], i_b};
            r_acc   <= '0;
            r_q_m1  <= 1'b0;
            r_cnt   <= CW'(NITER);
            r_hi    <= '0;
            r_lo    <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign o_busy = (r_state == ST_RUN);
  assign o_done = (r_state == ST_DONE);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
